// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers in-order responses in a small {pc, instr} FIFO and presents the head to decode.
module fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [6:0]      if_opcode
);

   localparam int unsigned     CW        = $clog2(DEPTH + 1);
   localparam int unsigned     PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     SW        = CW + 2;
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN     = ~XLEN'(3);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] resp_pc_q;
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [XLEN-1:0] fifo_instr [DEPTH];
   logic [PW-1:0]   rd_ptr_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   outstanding_q;
   logic [CW-1:0]   discard_q;
   logic            req_en_q;

   logic [SW-1:0]   occupancy;
   logic            req_fire;
   logic            resp_drop;
   logic            resp_push;
   logic            pop;
   logic [CW-1:0]   redirect_discard;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Every fetch holds a slot from issue until popped or flushed, so the sum never exceeds DEPTH.
   assign occupancy      = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);
   assign imem_req_valid = req_en_q && (occupancy < SW'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_drop = imem_resp_valid && (discard_q != '0);
   assign resp_push = imem_resp_valid && (discard_q == '0) && (outstanding_q != '0);

   // A response landing in the redirect cycle retires one in-flight slot either way.
   assign redirect_discard = discard_q + outstanding_q - CW'(resp_drop || resp_push);

   assign if_valid  = (count_q != '0);
   assign pop       = if_valid && id_ready;
   assign if_pc     = if_valid ? fifo_pc[rd_ptr_q]    : '0;
   assign if_instr  = if_valid ? fifo_instr[rd_ptr_q] : NOP_INSTR;
   assign if_opcode = if_instr[6:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC & ALIGN;
         resp_pc_q     <= RESET_PC & ALIGN;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         req_en_q      <= 1'b0;
      end else begin
         req_en_q <= 1'b1;
         if (redirect_valid) begin
            pc_q          <= redirect_pc & ALIGN;
            resp_pc_q     <= redirect_pc & ALIGN;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= redirect_discard;
         end else begin
            if (req_fire) pc_q <= pc_q + PC_STEP;
            if (resp_push) begin
               resp_pc_q <= resp_pc_q + PC_STEP;
               wr_ptr_q  <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp_push);
            discard_q     <= discard_q - CW'(resp_drop);
            count_q       <= count_q + CW'(resp_push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resp_push && !redirect_valid) begin
         fifo_pc[wr_ptr_q]    <= resp_pc_q;
         fifo_instr[wr_ptr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an in-order memory model answers fetches, and the
// expected delivery stream is the sequential PC run from the last reset or redirect target.
module tb_fetch_stage;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;

   fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_opcode      (if_opcode)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          ready_cyc;
   } mreq_t;

   exp_t        exp_q [$];
   mreq_t       memq  [$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          delivered = 0;
   int          resp_now = 0;
   logic [31:0] gen_pc;
   logic [31:0] model_req_pc;
   int          lat_min = 1, lat_max = 1;
   int          ready_pct = 100, resp_pct = 100;
   bit          rand_id = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h00A0_0113;
         32'h8:   return 32'h0020_81B3;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic top_up();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc    = gen_pc;
         e.instr = mem_word(gen_pc);
         exp_q.push_back(e);
         gen_pc += 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] target);
      exp_q.delete();
      gen_pc       = target & ~32'h3;
      model_req_pc = target & ~32'h3;
      top_up();
   endtask

   task automatic step();
      @(negedge clk);
      redirect_valid = 1'b0;
      if (rand_id) id_ready = ($urandom_range(0, 99) < 70);
      top_up();
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      restart_stream(target);
   endtask

   task automatic wait_delivered(input int n, input int budget, input string name);
      int start;
      int k;
      start = delivered;
      k = 0;
      while (delivered < start + n && k < budget) begin
         step();
         k++;
      end
      tests++;
      if (delivered < start + n) begin
         fails++;
         $display("FAIL %s: delivered %0d, required %0d", name, delivered - start, n);
      end
   endtask

   // Returns 3 time units into a cycle once n fetches are unanswered by the memory.
   task automatic wait_inflight(input int n, input int budget, input string name);
      int k;
      k = 0;
      do begin
         step();
         #3;
         k++;
      end while ((memq.size() + resp_now) < n && k < budget);
      tests++;
      if ((memq.size() + resp_now) < n) begin
         fails++;
         $display("FAIL %s: in flight %0d, required %0d", name, memq.size() + resp_now, n);
      end
   endtask

   // Memory model: in-order responses, at least one cycle after acceptance.
   initial begin
      mreq_t m;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         resp_now        = 0;
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
         if (!rst_n) begin
            memq.delete();
            imem_req_ready = 1'b0;
         end else begin
            if (memq.size() > 0 && memq[0].ready_cyc <= cyc && $urandom_range(0, 99) < resp_pct) begin
               m               = memq.pop_front();
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(m.addr);
               resp_now        = 1;
            end
            imem_req_ready = ($urandom_range(0, 99) < ready_pct);
            #4;
            if (rst_n) begin
               if (redirect_valid) check("req_during_redirect", 32'(imem_req_valid), 32'd0);
               if (imem_req_valid && imem_req_ready) begin
                  check("req_addr", imem_req_addr, model_req_pc);
                  check("credit", 32'((memq.size() + resp_now) < DEPTH), 32'd1);
                  m.addr      = imem_req_addr;
                  m.ready_cyc = cyc + $urandom_range(lat_min, lat_max);
                  memq.push_back(m);
                  model_req_pc += 32'd4;
               end
            end
         end
      end
   end

   // Monitor: every decode handshake pops the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && !redirect_valid) begin
            if (if_valid && id_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL scoreboard_empty: got pc %h, required no delivery", if_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("if_pc", if_pc, e.pc);
                  check("if_instr", if_instr, e.instr);
                  check("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
               end
               delivered++;
            end else if (!if_valid) begin
               check("empty_pc", if_pc, 32'd0);
               check("empty_instr", if_instr, NOP);
               check("empty_opcode", 32'(if_opcode), 32'h13);
            end
         end
      end
   end

   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int d0;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      restart_stream(RESET_PC);
      repeat (3) @(negedge clk);
      #4;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_if_opcode", 32'(if_opcode), 32'h13);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #2 check("req_after_release", 32'(imem_req_valid), 32'd0);

      // Sequential stream from reset, then sustained flow.
      wait_delivered(3, 20, "first_three");
      d0 = delivered;
      repeat (30) step();
      check("throughput", 32'((delivered - d0) >= 18), 32'd1);

      // Decode stall fills the buffer and stops fetching.
      step();
      id_ready = 1'b0;
      repeat (10) step();
      #4;
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_head_pc", if_pc, exp_q[0].pc);
      check("stall_head_instr", if_instr, exp_q[0].instr);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      id_ready = 1'b1;
      wait_delivered(4, 20, "stall_release");

      // Redirect with two fetches in flight.
      lat_min = 4; lat_max = 4;
      wait_inflight(2, 40, "two_inflight");
      step();
      do_redirect(32'h100);
      step();
      #4 check("flush_next_cycle", 32'(if_valid), 32'd0);
      wait_delivered(2, 60, "after_redirect_100");

      // Redirect on a response edge, then back-to-back redirects.
      lat_min = 1; lat_max = 1;
      wait_delivered(2, 20, "prime_b2b");
      begin
         int k;
         k = 0;
         do begin
            step();
            #1;
            k++;
         end while (!imem_resp_valid && k < 20);
         check("resp_for_coincident_redirect", 32'(imem_resp_valid), 32'd1);
      end
      do_redirect(32'h200);
      step();
      do_redirect(32'h300);
      step();
      wait_delivered(3, 40, "after_redirect_300");

      // Unaligned target and address wrap.
      step();
      do_redirect(32'h103);
      step();
      wait_delivered(2, 40, "after_redirect_103");
      step();
      do_redirect(32'hFFFF_FFF4);
      step();
      wait_delivered(5, 60, "address_wrap");

      // Asynchronous reset with fetches in flight.
      lat_min = 3; lat_max = 3;
      wait_inflight(2, 40, "inflight_before_reset");
      rst_n = 1'b0;
      #1;
      check("mid_rst_if_valid", 32'(if_valid), 32'd0);
      check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("mid_rst_if_pc", if_pc, 32'd0);
      restart_stream(RESET_PC);
      step();
      step();
      #2 rst_n = 1'b1;
      wait_delivered(4, 40, "restart_after_reset");

      // Randomized traffic with occasional redirects.
      rand_id   = 1'b1;
      ready_pct = 70;
      resp_pct  = 75;
      lat_min   = 1;
      lat_max   = 4;
      for (int i = 0; i < 1500; i++) begin
         step();
         if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      end
      rand_id   = 1'b0;
      ready_pct = 100;
      resp_pct  = 100;
      step();
      id_ready = 1'b1;
      wait_delivered(5, 100, "final_liveness");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
